// File: rtl/icache_direct_pkg.sv
// Shared constants for the direct-mapped instruction cache: FSM encodings and default geometry.
package icache_direct_pkg;

    typedef enum logic [1:0] {
        ICACHE_IDLE      = 2'd0,
        ICACHE_MISS      = 2'd1,
        ICACHE_WAIT_DROP = 2'd2
    } icache_state_e;

    localparam int ICACHE_INDEX_BITS_DEF = 6;
    localparam int ICACHE_ADDR_W_DEF     = 32;

endpackage

// File: rtl/icache_direct_tag_array.sv
// Valid/tag/data storage for icache_direct: combinational read, synchronous write,
// single-cycle clear of every valid bit. Everything freezes while en_i is low.
module icache_tag_array #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_W      = 24
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  en_i,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output logic                  rd_valid_o,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic [31:0]           rd_data_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]      wr_tag_i,
    input  logic [31:0]           wr_data_i,
    input  logic                  clr_i
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    // Clear wins over a same-cycle write so an invalidated fill never becomes visible.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else if (en_i) begin
            if (clr_i)
                valid_q <= '0;
            else if (wr_en_i)
                valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (en_i && wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache controller, one 32-bit word per line.
// Optional hit/miss counters enabled with ICACHE_STATS_EN.
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS_DEF,
    parameter int ADDR_W     = ICACHE_ADDR_W_DEF
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              flush_in,
    input  logic              inval_in,
    output logic              ins_valid,
    output logic [31:0]       ins_out,
    output logic              busy,
    output logic              mem_need,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [31:0]       mem_ins
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

    icache_state_e     state_q, state_d;
    logic              ins_valid_q, ins_valid_d;
    logic [31:0]       ins_out_q, ins_out_d;
    logic              mem_need_q, mem_need_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              killed_q, killed_d;
    logic              nofill_q, nofill_d;
    logic              busy_d;
    logic              wr_en;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [31:0]       rd_data;

    logic req_ok, lookup_hit;
    assign req_ok     = fetch_req && !flush_in;
    // A same-cycle invalidate wipes the line, so the lookup must not hit on it.
    assign lookup_hit = rd_valid && (rd_tag == fetch_addr[ADDR_W-1:INDEX_BITS+2]) && !inval_in;

    // The latched miss address doubles as the fill index/tag.
    icache_tag_array #(
        .INDEX_BITS(INDEX_BITS),
        .TAG_W     (TAG_W)
    ) u_tags (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .en_i      (rdy_in),
        .rd_idx_i  (fetch_addr[INDEX_BITS+1:2]),
        .rd_valid_o(rd_valid),
        .rd_tag_o  (rd_tag),
        .rd_data_o (rd_data),
        .wr_en_i   (wr_en),
        .wr_idx_i  (mem_addr_q[INDEX_BITS+1:2]),
        .wr_tag_i  (mem_addr_q[ADDR_W-1:INDEX_BITS+2]),
        .wr_data_i (mem_ins),
        .clr_i     (inval_in)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ICACHE_IDLE;
            ins_valid_q <= 1'b0;
            ins_out_q   <= '0;
            busy        <= 1'b0;
            mem_need_q  <= 1'b0;
            mem_addr_q  <= '0;
            killed_q    <= 1'b0;
            nofill_q    <= 1'b0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            ins_valid_q <= ins_valid_d;
            ins_out_q   <= ins_out_d;
            busy        <= busy_d;
            mem_need_q  <= mem_need_d;
            mem_addr_q  <= mem_addr_d;
            killed_q    <= killed_d;
            nofill_q    <= nofill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ICACHE_IDLE:      if (req_ok && !lookup_hit) state_d = ICACHE_MISS;
            ICACHE_MISS:      if (mem_ready) state_d = ICACHE_WAIT_DROP;
            ICACHE_WAIT_DROP: state_d = ICACHE_IDLE;
            default:          state_d = ICACHE_IDLE;
        endcase
    end

    always_comb begin
        ins_valid_d = 1'b0;
        ins_out_d   = ins_out_q;
        busy_d      = busy;
        mem_need_d  = mem_need_q;
        mem_addr_d  = mem_addr_q;
        killed_d    = killed_q;
        nofill_d    = nofill_q;
        wr_en       = 1'b0;
        unique case (state_q)
            ICACHE_IDLE: begin
                if (req_ok) begin
                    if (lookup_hit) begin
                        ins_valid_d = 1'b1;
                        ins_out_d   = rd_data;
                    end else begin
                        mem_need_d = 1'b1;
                        mem_addr_d = fetch_addr & ~ADDR_W'(3);
                        busy_d     = 1'b1;
                        killed_d   = 1'b0;
                        nofill_d   = 1'b0;
                    end
                end
            end
            ICACHE_MISS: begin
                killed_d = killed_q || flush_in || inval_in;
                nofill_d = nofill_q || inval_in;
                if (mem_ready) begin
                    mem_need_d = 1'b0;
                    wr_en      = !(nofill_q || inval_in);
                    if (!(killed_q || flush_in || inval_in)) begin
                        ins_valid_d = 1'b1;
                        ins_out_d   = mem_ins;
                    end
                    killed_d = 1'b0;
                    nofill_d = 1'b0;
                end
            end
            ICACHE_WAIT_DROP: busy_d = 1'b0;
            default: ;
        endcase
    end

    assign ins_valid = ins_valid_q;
    assign ins_out   = ins_out_q;
    assign mem_need  = mem_need_q;
    assign mem_addr  = mem_addr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        acc_lookup;
    assign acc_lookup = (state_q == ICACHE_IDLE) && req_ok;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rdy_in && acc_lookup) begin
            if (lookup_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
            else            miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Randomized scoreboard bench for icache_direct against an array-based cache model.
module tb_icache_direct;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1, rdy_in = 1'b1;
    logic        fetch_req = 1'b0, flush_in = 1'b0, inval_in = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        ins_valid, busy, mem_need;
    logic [31:0] ins_out, mem_addr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_ins = '0;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    icache_direct dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .flush_in(flush_in), .inval_in(inval_in),
        .ins_valid(ins_valid), .ins_out(ins_out), .busy(busy),
        .mem_need(mem_need), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_ins(mem_ins)
`ifdef ICACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    typedef struct { logic [31:0] data; int due; } exp_t;
    exp_t exp_q[$];

    int checks = 0, errors = 0, cyc = 0;
    bit          vld_m [64];
    logic [23:0] tag_m [64];
    logic [31:0] dat_m [64];
    int unsigned hits_m = 0, misses_m = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h10) return 32'h00A00093;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) vld_m[i] = 1'b0;
    endtask

    // Monitor: every delivered instruction must match the oldest expectation, on time.
    always @(negedge clk) begin
        if (ins_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ins_valid got=%h exp=none (cycle %0d)", ins_out, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (ins_out !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL response got=%h@%0d exp=%h@%0d", ins_out, cyc, e.data, e.due);
                end
            end
        end
    end

    task automatic do_inval();
        inval_in = 1'b1;
        @(negedge clk);
        inval_in = 1'b0;
        clear_model();
    endtask

    // mode: 0 plain, 1 flush mid-miss, 2 inval mid-miss, 3 reset mid-miss,
    //       4 flush with the request, 5 inval with the request. S = rdy stall cycles in miss.
    task automatic access(input logic [31:0] a, input int mode, input int S);
        int idx, w, kat, ki, c;
        logic [23:0] tg;
        bit hit;
        logic [31:0] ea;
        idx = int'(a[7:2]);
        tg  = a[31:8];
        ea  = a & ~32'd3;
        hit = vld_m[idx] && tag_m[idx] == tg && mode != 5;
        w   = $urandom_range(1, 6);
        kat = $urandom_range(0, w - 1);
        ki  = (kat == 0) ? 0 : kat + S;
        c   = cyc;
        fetch_req  = 1'b1;
        fetch_addr = ea | 32'($urandom_range(0, 3));
        flush_in   = (mode == 4);
        inval_in   = (mode == 5);
        if (mode == 4) begin
            @(negedge clk);
            fetch_req = 1'b0; flush_in = 1'b0;
            chk("flush_idle_need", {31'd0, mem_need}, 32'd0);
            return;
        end
        if (mode == 5) clear_model();
        if (hit) begin
            exp_q.push_back('{dat_m[idx], c + 1});
            hits_m++;
            @(negedge clk);
            fetch_req = 1'b0;
            chk("hit_no_need", {31'd0, mem_need}, 32'd0);
            return;
        end
        misses_m++;
        if (mode == 0 || mode == 5) exp_q.push_back('{memfn(ea), c + 2 + w + S});
        @(negedge clk);
        fetch_req = 1'b0; inval_in = 1'b0;
        chk("miss_need", {31'd0, mem_need}, 32'd1);
        chk("miss_addr", mem_addr, ea);
        chk("miss_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < w + S; i++) begin
            rdy_in   = !(S > 0 && i >= 1 && i < 1 + S);
            flush_in = (mode == 1 && i == ki);
            inval_in = (mode == 2 && i == ki);
            rst_in   = (mode == 3 && i == ki);
            @(negedge clk);
            rdy_in = 1'b1; flush_in = 1'b0; inval_in = 1'b0;
            if (mode == 2 && i == ki) clear_model();
            if (mode == 3 && i == ki) begin
                rst_in = 1'b0;
                clear_model();
                hits_m = 0; misses_m = 0;
                chk("rst_ins_valid", {31'd0, ins_valid}, 32'd0);
                chk("rst_ins_out", ins_out, 32'd0);
                chk("rst_mem_need", {31'd0, mem_need}, 32'd0);
                chk("rst_mem_addr", mem_addr, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                repeat (2) @(negedge clk);
                mem_ready = 1'b1; mem_ins = memfn(ea);
                @(negedge clk);
                mem_ready = 1'b0;
                chk("stray_ready_need", {31'd0, mem_need}, 32'd0);
                return;
            end
            chk("hold_need", {31'd0, mem_need}, 32'd1);
            chk("hold_addr", mem_addr, ea);
        end
        mem_ready = 1'b1; mem_ins = memfn(ea);
        @(negedge clk);
        mem_ready = 1'b0; mem_ins = $urandom;
        chk("drop_need", {31'd0, mem_need}, 32'd0);
        if (mode != 2) begin
            vld_m[idx] = 1'b1; tag_m[idx] = tg; dat_m[idx] = memfn(ea);
        end
        @(negedge clk);
    endtask

    task automatic chk_stats(input string nm);
`ifdef ICACHE_STATS_EN
        chk({nm, "_hit_cnt"}, hit_cnt, hits_m);
        chk({nm, "_miss_cnt"}, miss_cnt, misses_m);
`else
        if (nm.len() < 0) $display("%s", nm);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        repeat (2) @(negedge clk);
        rst_in = 1'b0;
        chk("reset_ins_valid", {31'd0, ins_valid}, 32'd0);
        chk("reset_ins_out", ins_out, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_mem_need", {31'd0, mem_need}, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk_stats("reset");

        access(32'h10, 0, 0);
        access(32'h10, 0, 0);
        chk_stats("first_two");
        access(32'h110, 0, 0);
        access(32'h10, 0, 0);
        access(32'h20, 1, 0);
        access(32'h20, 0, 0);
        for (int k = 0; k < 4; k++) access(32'h30 + 32'(k) * 4, 0, 0);
        do_inval();
        for (int k = 0; k < 4; k++) access(32'h30 + 32'(k) * 4, 0, 0);
        access(32'h70, 0, 3);
        access(32'h80, 3, 0);
        access(32'h80, 0, 0);
        chk_stats("directed");

        for (int n = 0; n < 400; n++) begin
            int r, s;
            logic [31:0] a;
            r = $urandom_range(0, 99);
            s = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            a = ({8'd0, 24'($urandom_range(0, 2) * 24'h01234)} << 8) | (32'($urandom_range(0, 15)) << 2);
            if      (r < 55) access(a, 0, s);
            else if (r < 65) access(a, 1, s);
            else if (r < 72) access(a, 2, s);
            else if (r < 77) access(a, 3, s);
            else if (r < 85) access(a, 4, 0);
            else if (r < 92) access(a, 5, s);
            else             do_inval();
        end
        repeat (4) @(negedge clk);
        chk_stats("final");
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped instruction cache between the instruction fetch unit and the memory controller's instruction port.
- On a hit, it returns a 32-bit instruction one cycle after the request.
- On a miss, it issues a 4-byte fetch through the memory controller's iCache_need / ins_addr / ins_ready / ins handshake, fills the line, then responds.
- Whole-cache invalidation is supported for fence.i / program reload.

Parameters:
- INDEX_BITS, 6, log2 of line count (default 64 lines, one 32-bit word per line).
- ADDR_W, 32, address width; tag = addr[ADDR_W-1 : INDEX_BITS+2], index = addr[INDEX_BITS+1:2].

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; synchronous, active-high
- rdy_in  input  1  global ready; block freezes all state while low
- fetch_req  input  1  fetch unit requests instruction at fetch_addr
- fetch_addr  input  32  word-aligned PC; bits [1:0] ignored
- flush_in  input  1  discard the pending request (branch redirect)
- inval_in  input  1  clear all valid bits
- ins_valid  output  1  one-cycle pulse: ins_out is valid for the accepted request
- ins_out  output  32  instruction
- busy  output  1  high while a miss is outstanding; fetch_req is ignored while busy
- mem_need  output  1  to memory controller iCache_need
- mem_addr  output  32  to memory controller ins_addr, word-aligned
- mem_ready  input  1  from memory controller ins_ready (one-cycle pulse)
- mem_ins  input  32  from memory controller ins

Behaviour:
- Reset (rst_in=1 at posedge):
  - state=IDLE.
  - All valid bits 0.
  - ins_valid=0, ins_out=0, busy=0, mem_need=0, mem_addr=0.
  - Reset overrides rdy_in.
  - Reset mid-miss abandons the fill. The memory controller finishes its own transfer; the later mem_ready pulse arrives in IDLE and is ignored.
- rdy_in=0: no register changes.
- States:
  - IDLE (accepts requests)
  - MISS (mem_need held high)
  - WAIT_DROP (one cycle with mem_need low before returning to IDLE)
- IDLE with fetch_req=1 and flush_in=0:
  - Hit (valid[index] and tag match): ins_valid=1 and ins_out=data[index] on the next edge; stay IDLE.
  - Miss: latch the request address, set mem_need=1 and mem_addr={fetch_addr[31:2],2'b00}, busy=1, go to MISS.
- IDLE with no request: ins_valid=0.
- MISS:
  - mem_need and mem_addr stay stable until mem_ready=1.
  - On mem_ready: write data/tag/valid for the latched index, and drop mem_need on the same edge.
    - The memory controller's one-cycle post-transfer stall guarantees it does not restart a fetch.
  - Response: ins_valid=1 and ins_out=mem_ins, unless the request was flushed; if flushed, ins_valid stays 0. Go to WAIT_DROP.
- WAIT_DROP: busy=0, go to IDLE. No request is accepted in this cycle.
- flush_in:
  - In IDLE, the same-cycle request is dropped.
  - In MISS, set a sticky "killed" flag. The fill still completes and writes the line, but no ins_valid is produced. The flag clears on leaving MISS.
- inval_in: clears all valid bits on the next edge.
  - If asserted during MISS, the in-flight fill is not written, and any response is suppressed as for flush.
  - inval_in combined with a same-cycle hit lookup: the lookup is treated as a miss.
- Latency:
  - Hit: 1 cycle.
  - Miss: memory latency (6 cycles with the current memory controller) + 1 cycle.
- ins_valid is high for exactly one cycle per delivered instruction.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined:
  - Adds output ports hit_cnt[31:0] and miss_cnt[31:0], reset to 0.
  - Each increments once per accepted non-flushed lookup (hit, or miss entry); both wrap at 2^32.
  - Counters freeze when rdy_in=0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared constants go in const.v:
  - state encodings ICACHE_IDLE / ICACHE_MISS / ICACHE_WAIT_DROP
  - default INDEX_BITS
- Natural sub-module: icache_tag_array.
  - Holds the valid, tag and data arrays.
  - Combinational read port; synchronous write port plus global valid clear.
  - The controller FSM stays in icache_direct.

Test Plan:
- Cold miss, address 0x00000010: mem_need=1 with mem_addr=0x10. Memory returns 0x00A00093 → exactly one ins_valid pulse with ins_out=0x00A00093; busy returns to 0.
- Repeat request to 0x10 → ins_valid the next cycle and no mem_need.
- Conflict: request 0x10, then 0x110 (same index, INDEX_BITS=6) → miss and refill. A following request to 0x10 misses again.
- flush_in during MISS: no ins_valid. mem_need drops on mem_ready. A subsequent request to the same address hits.
- inval_in after filling 4 lines: all 4 addresses miss. rdy_in held low 3 cycles mid-miss: mem_need and mem_addr unchanged, completion delayed by 3 cycles.
- rst_in asserted mid-MISS: all outputs 0 next cycle, and the stray mem_ready is ignored.
- With ICACHE_STATS_EN: after the first two scenarios, hit_cnt=1 and miss_cnt=1.
